threshold_stream: RTL and testbench
===================================

THRESHOLD_STREAM -- requirements
Module: threshold_stream

Interface
REQ-001 SHALL have parameter WIDTH_PX, default 64, pixels per line.
REQ-002 SHALL have parameter HEIGHT_PX, default 64, lines per frame.
REQ-003 SHALL have parameter PIX_W, default 8, bits per pixel, unsigned.
REQ-004 SHALL have parameter LANES, default 1, pixels per beat; WIDTH_PX % LANES == 0 is checked at elaboration.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cfg_mode  input  2  0 binary, 1 inverse binary, 2 truncate, 3 to-zero.
REQ-008 SHALL have port cfg_thr  input  PIX_W  threshold.
REQ-009 SHALL have port in_valid  input  1  input beat valid.
REQ-010 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-011 SHALL have port in_data  input  LANES*PIX_W  pixels; lane 0 in LSBs is the leftmost pixel.
REQ-012 SHALL have port out_valid  output  1  output beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_data  output  LANES*PIX_W  thresholded pixels, same lane order.
REQ-015 SHALL have port out_eol  output  1  beat is the last of a line.
REQ-016 SHALL have port out_eof  output  1  beat is the last of a frame.
REQ-017 SHALL have port busy  output  1  frame in progress.
REQ-018 SHALL have port frame_done  output  1  one-cycle pulse when the out_eof beat is accepted.

Function
REQ-019 Per lane, with p = pixel, t = active threshold, M = 2^PIX_W-1, and strict comparison p > t: mode 0 gives M else 0; mode 1 gives 0 else M; mode 2 gives t else p; mode 3 gives p else 0.
REQ-020 cfg_mode and cfg_thr SHALL be sampled into shadow registers only on the first accepted beat of a frame; changes mid-frame SHALL have no effect until the next frame.
REQ-021 The first beat of a frame SHALL use the newly sampled configuration.
REQ-022 A single registered output stage gives latency 1: a beat accepted at edge N SHALL be presented on out_* after edge N.
REQ-023 in_ready SHALL be !out_valid || out_ready, combinationally, enabling one beat per cycle at full throughput.
REQ-024 While out_valid && !out_ready, out_data, out_eol and out_eof SHALL hold stable.
REQ-025 A column counter SHALL count 0..WIDTH_PX/LANES-1 and a row counter 0..HEIGHT_PX-1, both advancing on accepted input beats; the column counter wraps to 0 and increments the row counter; after the last beat both wrap to 0.
REQ-026 out_eol SHALL be 1 for the beat at the last column, and out_eof for the beat at the last column of the last row.
REQ-027 busy SHALL rise on the first accepted beat of a frame and fall on the cycle after frame_done.
REQ-028 If the last beat of frame K and the first beat of frame K+1 occur on consecutive cycles, there SHALL be no bubble, and busy SHALL stay 1.

Reset
REQ-029 While rst is 1 at a clk edge, out_valid, out_eol, out_eof, busy, frame_done, the counters and the shadow registers SHALL become 0, and out_data SHALL become 0.
REQ-030 A reset mid-frame SHALL discard the partial frame and the pending output beat; the next accepted beat SHALL be treated as row 0, column 0.
REQ-031 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-032 With macro THRESH_COUNT_EN defined, an output port above_cnt of width $clog2(WIDTH_PX*HEIGHT_PX+1) SHALL be present.
REQ-033 above_cnt SHALL count pixels with p > t across all lanes in the current frame.
REQ-034 above_cnt SHALL be updated in the cycle in which frame_done pulses, and SHALL hold the count of the completed frame until the next frame_done.
REQ-035 above_cnt SHALL reset to 0.
REQ-036 Without THRESH_COUNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Defaults, mode 0, thr 128, pixels 127/128/129/255: outputs SHALL be 0/0/255/255, each one cycle after acceptance.
REQ-038 LANES=4, modes 1..3, thr 100, beat {50,100,101,200}: outputs SHALL be {255,255,0,0}, {50,100,100,100} and {0,0,101,200}.
REQ-039 Full 64x64 frame with out_ready toggling randomly: there SHALL be 4096 beats, out_eol on every 64th beat, a single out_eof, a single frame_done pulse, and no data change while stalled.
REQ-040 Changing cfg_thr from 128 to 10 at row 5: the rest of the frame SHALL use 128 and the next frame SHALL use 10.
REQ-041 Asserting rst at row 30 then restarting: the first beat SHALL be row 0, column 0, and eof SHALL occur after exactly 4096 new beats.
REQ-042 With THRESH_COUNT_EN, an image of ramp values 0..255 repeated, thr 128: above_cnt SHALL be 127*16 = 2032.

Source files
------------

// File: rtl/threshold_stream.sv
// -----------------------------------------------------------------------------
// threshold_stream
//
// Purpose:
//   Streaming per-pixel thresholding of a raster image. LANES pixels per beat
//   are thresholded against a per-frame shadowed configuration. The output
//   passes through one registered stage with valid/ready flow control. Line
//   and frame markers are generated from internal column/row counters.
//
// Optional feature:
//   THRESH_COUNT_EN - when defined, adds output above_cnt. It reports how many
//                     pixels of the last completed frame exceeded the
//                     threshold.
//
// Parameters:
//   WIDTH_PX  pixels per line (must be a multiple of LANES)
//   HEIGHT_PX lines per frame
//   PIX_W     bits per pixel (unsigned)
//   LANES     pixels per beat
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   cfg_mode    0 binary, 1 inverse binary, 2 truncate, 3 to-zero
//   cfg_thr     threshold
//   in_valid    input beat valid
//   in_ready    input beat accepted when in_valid && in_ready
//   in_data     LANES pixels, lane 0 (LSBs) is leftmost
//   out_valid   output beat valid
//   out_ready   downstream accepts
//   out_data    thresholded pixels, same lane order
//   out_eol     beat is last of a line
//   out_eof     beat is last of a frame
//   busy        frame in progress
//   frame_done  one-cycle pulse after the out_eof beat is accepted
//   above_cnt   (THRESH_COUNT_EN only) pixels > threshold in the last frame
// -----------------------------------------------------------------------------
module threshold_stream #(
    parameter int WIDTH_PX  = 64,
    parameter int HEIGHT_PX = 64,
    parameter int PIX_W     = 8,
    parameter int LANES     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cfg_mode,
    input  logic [PIX_W-1:0]         cfg_thr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*PIX_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*PIX_W-1:0]   out_data,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic                     busy,
    output logic                     frame_done
`ifdef THRESH_COUNT_EN
    ,
    output logic [$clog2(WIDTH_PX*HEIGHT_PX+1)-1:0] above_cnt
`endif
);

    localparam int COLS  = WIDTH_PX / LANES;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (HEIGHT_PX > 1) ? $clog2(HEIGHT_PX) : 1;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    generate
        if (WIDTH_PX % LANES != 0) begin : g_bad_lanes
            $error("threshold_stream: WIDTH_PX must be a multiple of LANES");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic [1:0]              r_mode;
    logic [PIX_W-1:0]        r_thr;
    logic                    r_out_valid;
    logic [LANES*PIX_W-1:0]  r_out_data;
    logic                    r_out_eol;
    logic                    r_out_eof;
    logic                    r_frame_done;
    logic                    r_busy;
    // Set while a frame has started at the input but its last beat has not
    // yet been accepted. It keeps busy high across back-to-back frames.
    // A single-beat frame never sets it.
    logic                    r_open;

    // ------------------------------------------------------------------
    // Handshake and position decode
    // ------------------------------------------------------------------
    logic                    w_accept;
    logic                    w_first;
    logic                    w_last_col;
    logic                    w_last;
    logic [1:0]              w_mode;
    logic [PIX_W-1:0]        w_thr;
    logic [LANES*PIX_W-1:0]  w_out_data;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_first    = (r_col == '0) && (r_row == '0);
    assign w_last_col = (r_col == COL_W'(COLS - 1));
    assign w_last     = w_last_col && (r_row == ROW_W'(HEIGHT_PX - 1));

    // The first beat of a frame bypasses the shadow registers. It therefore
    // sees the configuration that is being sampled on that same edge.
    assign w_mode = w_first ? cfg_mode : r_mode;
    assign w_thr  = w_first ? cfg_thr  : r_thr;

`ifdef THRESH_COUNT_EN
    localparam int CNT_W  = $clog2(WIDTH_PX*HEIGHT_PX+1);
    localparam int BEAT_W = $clog2(LANES+1);
    logic [LANES-1:0]        w_above;
    logic [BEAT_W-1:0]       w_beat_above;
    logic [BEAT_W-1:0]       r_out_above;
    logic [CNT_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_above_cnt;
`endif

    // ------------------------------------------------------------------
    // Per-lane threshold function
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PIX_W-1:0] w_pix;
            logic [PIX_W-1:0] w_res;
            logic             w_gt;

            assign w_pix = in_data[gi*PIX_W +: PIX_W];
            assign w_gt  = (w_pix > w_thr);

            always_comb begin
                w_res = '0;
                case (w_mode)
                    2'd0:    w_res = w_gt ? PIX_MAX : '0;
                    2'd1:    w_res = w_gt ? '0 : PIX_MAX;
                    2'd2:    w_res = w_gt ? w_thr : w_pix;
                    default: w_res = w_gt ? w_pix : '0;
                endcase
            end

            assign w_out_data[gi*PIX_W +: PIX_W] = w_res;
`ifdef THRESH_COUNT_EN
            assign w_above[gi] = w_gt;
`endif
        end
    endgenerate

`ifdef THRESH_COUNT_EN
    always_comb begin
        w_beat_above = '0;
        for (int i = 0; i < LANES; i++) begin
            w_beat_above = w_beat_above + BEAT_W'(w_above[i]);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Counters, shadow config, output stage, status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_mode       <= '0;
            r_thr        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_eol    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_open       <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_mode <= cfg_mode;
                    r_thr  <= cfg_thr;
                end
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                r_out_valid <= 1'b1;
                r_out_data  <= w_out_data;
                r_out_eol   <= w_last_col;
                r_out_eof   <= w_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            r_frame_done <= r_out_valid && out_ready && r_out_eof;

            if (w_accept) begin
                if (w_last) begin
                    r_open <= 1'b0;
                end else if (w_first) begin
                    r_open <= 1'b1;
                end
            end

            // A new frame starting has priority over the completion of
            // the previous one, so back-to-back frames keep busy high.
            if (w_accept && w_first) begin
                r_busy <= 1'b1;
            end else if (r_frame_done && !r_open) begin
                r_busy <= 1'b0;
            end
        end
    end

`ifdef THRESH_COUNT_EN
    // Accumulation follows the output side, so a following frame whose
    // first beats are already in flight cannot pollute the finished count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_above <= '0;
            r_acc       <= '0;
            r_above_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_out_above <= w_beat_above;
            end
            if (r_out_valid && out_ready) begin
                if (r_out_eof) begin
                    r_above_cnt <= r_acc + CNT_W'(r_out_above);
                    r_acc       <= '0;
                end else begin
                    r_acc <= r_acc + CNT_W'(r_out_above);
                end
            end
        end
    end

    assign above_cnt = r_above_cnt;
`endif

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_eol    = r_out_eol;
    assign out_eof    = r_out_eof;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_threshold_stream.sv
// -----------------------------------------------------------------------------
// tb_threshold_stream
//
// Randomized bench for threshold_stream. It uses two instances:
//   u_dut  - default geometry (64x64, 8-bit, 1 lane). Its stream is checked
//            against a frame-position based reference model.
//   u_dut4 - 8x2, 4 lanes. It is used for multi-lane mode tables and for
//            back-to-back frames.
// Optional: THRESH_COUNT_EN also checks above_cnt.
// -----------------------------------------------------------------------------
module tb_threshold_stream;

    localparam int W     = 64;
    localparam int H     = 64;
    localparam int TOTAL = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_thr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_eol;
    logic        out_eof;
    logic        busy;
    logic        frame_done;

    logic [1:0]  cfg_mode4;
    logic [7:0]  cfg_thr4;
    logic        in_valid4;
    logic        in_ready4;
    logic [31:0] in_data4;
    logic        out_valid4;
    logic        out_ready4;
    logic [31:0] out_data4;
    logic        out_eol4;
    logic        out_eof4;
    logic        busy4;
    logic        frame_done4;

`ifdef THRESH_COUNT_EN
    logic [12:0] above_cnt;
    logic [4:0]  above_cnt4;
`endif

    threshold_stream u_dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_mode   (cfg_mode),
        .cfg_thr    (cfg_thr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef THRESH_COUNT_EN
        ,
        .above_cnt  (above_cnt)
`endif
    );

    threshold_stream #(
        .WIDTH_PX  (8),
        .HEIGHT_PX (2),
        .PIX_W     (8),
        .LANES     (4)
    ) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .cfg_mode   (cfg_mode4),
        .cfg_thr    (cfg_thr4),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_data    (in_data4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .out_data   (out_data4),
        .out_eol    (out_eol4),
        .out_eof    (out_eof4),
        .busy       (busy4),
        .frame_done (frame_done4)
`ifdef THRESH_COUNT_EN
        ,
        .above_cnt  (above_cnt4)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference threshold rule for a single pixel
    function automatic logic [7:0] ref_pix(input logic [1:0] m, input logic [7:0] t, input logic [7:0] p);
        logic gt;
        gt = (p > t);
        case (m)
            2'd0:    return gt ? 8'd255 : 8'd0;
            2'd1:    return gt ? 8'd0 : 8'd255;
            2'd2:    return gt ? t : p;
            default: return gt ? p : 8'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model / scoreboard for u_dut. It works from the beat index
    // within the frame. Configuration is latched when the index is zero.
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] d;
        logic       eol;
        logic       eof;
    } beat_t;

    beat_t      exp_q[$];
    int         exp_above_q[$];
    int         m_idx     = 0;
    logic [1:0] m_mode    = '0;
    logic [7:0] m_thr     = '0;
    int         m_above   = 0;
    logic       done_due  = 1'b0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out  = '0;
    logic       prev_acc  = 1'b0;
    int         n_out  = 0;
    int         n_eol  = 0;
    int         n_eof  = 0;
    int         n_done = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_above_q.delete();
            m_idx      = 0;
            m_above    = 0;
            done_due   = 1'b0;
            prev_stall = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (prev_acc) check_eq("latency_valid", 64'(out_valid), 64'd1);
            if (prev_stall) check_eq("stall_hold", {out_valid, out_data, out_eol, out_eof}, {1'b1, prev_out});
            if (done_due || frame_done) begin
                check_eq("frame_done", 64'(frame_done), 64'(done_due));
                if (frame_done) n_done++;
`ifdef THRESH_COUNT_EN
                if (done_due && exp_above_q.size() > 0) begin
                    check_eq("above_cnt", 64'(above_cnt), 64'(exp_above_q.pop_front()));
                end
`endif
            end
            done_due = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_eq("out_beat", {out_data, out_eol, out_eof}, {e.d, e.eol, e.eof});
                    n_out++;
                    if (out_eol) n_eol++;
                    if (out_eof) begin
                        n_eof++;
                        done_due = 1'b1;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_data, out_eol, out_eof};
            prev_acc   = in_valid && in_ready;
            if (prev_acc) begin
                beat_t b;
                if (m_idx == 0) begin
                    m_mode = cfg_mode;
                    m_thr  = cfg_thr;
                end
                b.d   = ref_pix(m_mode, m_thr, in_data);
                b.eol = ((m_idx % W) == W - 1);
                b.eof = (m_idx == TOTAL - 1);
                exp_q.push_back(b);
                if (in_data > m_thr) m_above++;
                if (b.eof) begin
                    exp_above_q.push_back(m_above);
                    m_above = 0;
                end
                m_idx = (m_idx + 1) % TOTAL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left just after a rising edge)
    // ------------------------------------------------------------------
    int ramp_ctr = 0;

    task automatic stream(input int n, input bit ramp);
        int got;
        int guard;
        got   = 0;
        guard = 0;
        while (got < n && guard < n * 20) begin
            in_valid  = (($urandom % 8) != 0);
            in_data   = ramp ? 8'(ramp_ctr) : 8'($urandom);
            out_ready = (($urandom % 4) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                got++;
                ramp_ctr++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (got < n) check_eq("stream_timeout", 64'(got), 64'(n));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic send_dir(input logic [7:0] p, input logic [7:0] exp);
        in_valid  = 1'b1;
        in_data   = p;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("dir_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("dir_pixel", {out_valid, out_data}, {1'b1, exp});
        @(posedge clk);
        #1;
    endtask

    int base_out, base_eol, base_eof, base_done;

    task automatic mark();
        base_out  = n_out;
        base_eol  = n_eol;
        base_eof  = n_eof;
        base_done = n_done;
    endtask

    task automatic check_frame_counts(input string tag, input int beats, input int eols);
        check_eq({tag, "_beats"}, 64'(n_out - base_out), 64'(beats));
        check_eq({tag, "_eol"},   64'(n_eol - base_eol), 64'(eols));
        check_eq({tag, "_eof"},   64'(n_eof - base_eof), 64'd1);
        check_eq({tag, "_done"},  64'(n_done - base_done), 64'd1);
    endtask

    logic [31:0] exp4 [1:3];

    initial begin
        exp4[1] = 32'h0000FFFF;
        exp4[2] = 32'h64646432;
        exp4[3] = 32'hC8650000;

        rst = 1'b1;
        cfg_mode = 2'd0;  cfg_thr = 8'd128;
        in_valid = 1'b0;  in_data = '0;  out_ready = 1'b1;
        cfg_mode4 = 2'd0; cfg_thr4 = 8'd100;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid",  64'(out_valid), 64'd0);
        check_eq("rst_out_data",   64'(out_data), 64'd0);
        check_eq("rst_eol_eof",    {out_eol, out_eof}, 64'd0);
        check_eq("rst_busy",       64'(busy), 64'd0);
        check_eq("rst_frame_done", 64'(frame_done), 64'd0);
        check_eq("rst_in_ready",   64'(in_ready), 64'd1);
        check_eq("rst_out_valid4", 64'(out_valid4), 64'd0);
`ifdef THRESH_COUNT_EN
        check_eq("rst_above_cnt",  64'(above_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Frame 1: directed start, threshold change at row 5
        mark();
        send_dir(8'd127, 8'd0);
        send_dir(8'd128, 8'd0);
        send_dir(8'd129, 8'd255);
        send_dir(8'd255, 8'd255);
        @(negedge clk);
        check_eq("busy_mid_frame", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        stream(5 * W - 4, 1'b0);
        cfg_thr = 8'd10;
        stream(TOTAL - 5 * W, 1'b0);
        drain();
        check_frame_counts("frame1", TOTAL, H);
        @(negedge clk);
        check_eq("busy_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Frame 2 (thr 10), then reset part-way through frame 3
        mark();
        cfg_mode = 2'($urandom_range(0, 3));
        stream(TOTAL + 30 * W, 1'b0);
        @(negedge clk);
        check_eq("busy_frame3", 64'(busy), 64'd1);
        check_eq("frame2_eof",  64'(n_eof - base_eof), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_busy",      64'(busy), 64'd0);
        check_eq("midrst_in_ready",  64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Frame after reset: must be exactly TOTAL beats from row 0, col 0
        mark();
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_thr  = 8'($urandom);
        stream(TOTAL, 1'b0);
        drain();
        check_frame_counts("after_rst", TOTAL, H);

        // Ramp frame for the above-threshold count
        mark();
        cfg_mode = 2'd0;
        cfg_thr  = 8'd128;
        ramp_ctr = 0;
        stream(TOTAL, 1'b1);
        drain();
        check_frame_counts("ramp", TOTAL, H);
`ifdef THRESH_COUNT_EN
        check_eq("ramp_above_cnt", 64'(above_cnt), 64'd2032);
`endif

        // Four-lane instance: modes 1..3 on back-to-back 4-beat frames
        for (int m = 1; m <= 3; m++) begin
            cfg_mode4 = 2'(m);
            cfg_thr4  = 8'd100;
            for (int k = 0; k < 4; k++) begin
                in_valid4 = 1'b1;
                in_data4  = (k == 0) ? 32'hC8656432 : 32'h0;
                @(negedge clk);
                check_eq("l4_in_ready", 64'(in_ready4), 64'd1);
                if (k == 0 && m > 1) check_eq("l4_busy_boundary", 64'(busy4), 64'd1);
                if (k == 1) check_eq("l4_mode_out", 64'(out_data4), 64'(exp4[m]));
                @(posedge clk);
                #1;
            end
        end
        in_valid4 = 1'b0;
        @(negedge clk);
        check_eq("l4_eol_eof", {out_valid4, out_eol4, out_eof4}, 64'd7);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("l4_frame_done", 64'(frame_done4), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("l4_busy_fall", 64'(busy4), 64'd0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
